// File: rtl/voice_allocator_pkg.sv
// Shared constants and state encoding for the MIDI voice allocator.
// The parser and the victim picker both build on these definitions.
package voice_allocator_pkg;

  localparam logic [7:0] MIDI_NOTE_OFF    = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON     = 8'h90;
  localparam logic [7:0] MIDI_STATUS_MASK = 8'hF0;
  localparam logic [7:0] AGE_MAX          = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    DATA1,
    DATA2,
    ALLOC,
    SEND0,
    SEND1,
    SEND2
  } state_t;

  // Note-on or note-off on any channel (omni mode).
  function automatic logic is_note_status(input logic [7:0] b);
    return ((b & MIDI_STATUS_MASK) == MIDI_NOTE_OFF) ||
           ((b & MIDI_STATUS_MASK) == MIDI_NOTE_ON);
  endfunction

endpackage

// File: rtl/voice_allocator_pick.sv
// Combinational victim selection: retrigger a voice already holding the note,
// else the lowest free voice, else steal the oldest busy voice (ties to lowest index).
module voice_pick #(
  parameter  int NUM_VOICES = 4,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0] i_busy,
  input  logic [6:0]            i_note [NUM_VOICES],
  input  logic [7:0]            i_age  [NUM_VOICES],
  input  logic [6:0]            i_req_note,
  output logic [IDX_W-1:0]      o_index,
  output logic                  o_steal
);

  logic       w_found;
  logic [7:0] w_best_age;

  always_comb begin
    o_index    = '0;
    o_steal    = 1'b0;
    w_found    = 1'b0;
    w_best_age = i_age[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_found && i_busy[i] && (i_note[i] == i_req_note)) begin
        o_index = IDX_W'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_found && !i_busy[i]) begin
        o_index = IDX_W'(i);
        w_found = 1'b1;
      end
    end
    // Strict greater-than keeps the lowest index on equal ages.
    if (!w_found) begin
      o_steal = 1'b1;
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (i_age[i] > w_best_age) begin
          w_best_age = i_age[i];
          o_index    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// MIDI note-on/off parser that assigns each note to one of NUM_VOICES voices
// and forwards the three-byte message to the chosen voice.
// Handshake: a byte on midi_data transfers on a rising edge where midi_valid and
// midi_ready are both high; midi_ready depends only on state, never on midi_valid.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            midi_data,
  input  logic                  midi_valid,
  output logic                  midi_ready,
  output logic [7:0]            voice_data,
  output logic [NUM_VOICES-1:0] voice_valid,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  steal,
  output state_t                o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_on;
  logic [6:0]            r_note;
  logic [6:0]            r_vel;
  logic [IDX_W-1:0]      r_sel;
  logic [NUM_VOICES-1:0] r_busy;
  logic [6:0]            r_note_tab [NUM_VOICES];
  logic [7:0]            r_age      [NUM_VOICES];

  logic                  w_accept;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_steal;
  logic [IDX_W-1:0]      w_off_idx;
  logic                  w_off_hit;

  assign midi_ready  = (r_state == IDLE) || (r_state == DATA1) || (r_state == DATA2);
  assign w_accept    = midi_valid && midi_ready;
  assign voice_busy  = r_busy;
  assign steal       = (r_state == ALLOC) && r_is_on && w_pick_steal;
  assign o_dbg_state = r_state;

  voice_pick #(.NUM_VOICES(NUM_VOICES)) u_pick (
    .i_busy     (r_busy),
    .i_note     (r_note_tab),
    .i_age      (r_age),
    .i_req_note (r_note),
    .o_index    (w_pick_idx),
    .o_steal    (w_pick_steal)
  );

  always_comb begin
    w_off_hit = 1'b0;
    w_off_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_off_hit && r_busy[i] && (r_note_tab[i] == r_note)) begin
        w_off_hit = 1'b1;
        w_off_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DATA1, DATA2: begin
        // A status byte restarts the parse from any parse state.
        if (w_accept) begin
          if (midi_data[7])            w_next = is_note_status(midi_data) ? DATA1 : IDLE;
          else if (r_state == DATA1)   w_next = DATA2;
          else if (r_state == DATA2)   w_next = ALLOC;
        end
      end
      ALLOC:   w_next = (r_is_on || w_off_hit) ? SEND0 : IDLE;
      SEND0:   w_next = SEND1;
      SEND1:   w_next = SEND2;
      SEND2:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    voice_data  = '0;
    voice_valid = '0;
    case (r_state)
      SEND0: voice_data = r_is_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF;
      SEND1: voice_data = {1'b0, r_note};
      SEND2: voice_data = r_is_on ? {1'b0, r_vel} : 8'h00;
      default: voice_data = '0;
    endcase
    if ((r_state == SEND0) || (r_state == SEND1) || (r_state == SEND2))
      voice_valid = NUM_VOICES'(1) << r_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_on <= 1'b0;
      r_note  <= '0;
      r_vel   <= '0;
      r_sel   <= '0;
      r_busy  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note_tab[i] <= '0;
        r_age[i]      <= '0;
      end
    end else begin
      if (w_accept) begin
        // A zero-velocity note-on is folded into a note-off here.
        if (midi_data[7]) begin
          r_is_on <= ((midi_data & MIDI_STATUS_MASK) == MIDI_NOTE_ON);
        end else if (r_state == DATA1) begin
          r_note <= midi_data[6:0];
        end else if (r_state == DATA2) begin
          r_vel <= midi_data[6:0];
          if (midi_data[6:0] == 7'd0) r_is_on <= 1'b0;
        end
      end
      if (r_state == ALLOC) begin
        if (r_is_on) begin
          r_sel <= w_pick_idx;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == w_pick_idx) begin
              r_busy[i]     <= 1'b1;
              r_note_tab[i] <= r_note;
              r_age[i]      <= '0;
            end else if (r_busy[i] && (r_age[i] != AGE_MAX)) begin
              r_age[i] <= r_age[i] + 8'd1;
            end
          end
        end else if (w_off_hit) begin
          r_sel <= w_off_idx;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == w_off_idx) r_busy[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
